// File: rtl/arc_pkg.sv
// Shared types and constants for the ARC MIPS ID/EX stage: ALU opcodes,
// forwarding source select and the registered ID/EX record.
package arc_pkg;

  localparam int ARC_DATA_W = 32;
  localparam int ARC_REG_AW = 5;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SEQ = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // An all-zero record is a bubble: invalid, no register/memory side effects.
  typedef struct packed {
    logic                  valid;
    logic [3:0]            alu_ctrl;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic [ARC_REG_AW-1:0] wr_addr;
    logic [ARC_REG_AW-1:0] rs_addr;
    logic [ARC_REG_AW-1:0] rt_addr;
    logic [4:0]            shamt;
    logic [ARC_DATA_W-1:0] rs_val;
    logic [ARC_DATA_W-1:0] rt_val;
    logic [ARC_DATA_W-1:0] imm;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Writeback-side bypass bundle: the EX/MEM and MEM/WB register-write ports
// that the forwarding logic snoops.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              ex_we;
  logic [REG_AW-1:0] ex_dst;
  logic [DATA_W-1:0] ex_res;
  logic              mw_we;
  logic [REG_AW-1:0] mw_dst;
  logic [DATA_W-1:0] mw_res;

  modport master (output ex_we, ex_dst, ex_res, mw_we, mw_dst, mw_res);
  modport slave  (input  ex_we, ex_dst, ex_res, mw_we, mw_dst, mw_res);
endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding select: picks the youngest in-flight writer of a
// register, never forwarding register 0.
module fwd_unit
  import arc_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  id_ex_stage_if.slave      wb,
  input  logic [REG_AW-1:0] i_src,
  output fwd_sel_e          o_sel
);

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    o_sel = FWD_RF;
    if (FWD_EN != 0 && i_src != '0) begin
      if (wb.ex_we && wb.ex_dst == i_src)      o_sel = FWD_EXMEM;
      else if (wb.mw_we && wb.mw_dst == i_src) o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, load-use bubble
// insertion, flush and hold.
module id_ex_stage
  import arc_pkg::*;
#(
  parameter int DATA_W = ARC_DATA_W,
  parameter int REG_AW = ARC_REG_AW,
  parameter int FWD_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_con_IdValid,
  input  logic [DATA_W-1:0] i_data_RsVal,
  input  logic [DATA_W-1:0] i_data_RtVal,
  input  logic [DATA_W-1:0] i_data_Imm,
  input  logic [REG_AW-1:0] i_data_RsAddr,
  input  logic [REG_AW-1:0] i_data_RtAddr,
  input  logic [REG_AW-1:0] i_data_RdAddr,
  input  logic [4:0]        i_data_shamt,
  input  logic [3:0]        i_con_AluCtrl,
  input  logic              i_con_AluSrc,
  input  logic              i_con_RegDst,
  input  logic              i_con_RegWrite,
  input  logic              i_con_MemRead,
  input  logic              i_con_MemWrite,
  input  logic              i_con_MemToReg,
  input  logic              i_con_Flush,
  input  logic              i_con_Hold,
  input  logic              i_con_ExMemRegWrite,
  input  logic [REG_AW-1:0] i_data_ExMemDst,
  input  logic [DATA_W-1:0] i_data_ExMemRes,
  input  logic              i_con_MemWbRegWrite,
  input  logic [REG_AW-1:0] i_data_MemWbDst,
  input  logic [DATA_W-1:0] i_data_MemWbRes,
  output logic [DATA_W-1:0] o_data_A,
  output logic [DATA_W-1:0] o_data_B,
  output logic [3:0]        o_con_AluCtrl,
  output logic [4:0]        o_data_shamt,
  output logic [DATA_W-1:0] o_data_StoreData,
  output logic [REG_AW-1:0] o_data_WrAddr,
  output logic              o_con_RegWrite,
  output logic              o_con_MemRead,
  output logic              o_con_MemWrite,
  output logic              o_con_MemToReg,
  output logic              o_con_ExValid,
  output logic              o_con_Stall
);

  id_ex_t            ex_q, ex_d, cap;
  logic              load_use, rt_hit;
  fwd_sel_e          sel_rs, sel_rt;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_wb ();

  assign u_wb.ex_we  = i_con_ExMemRegWrite;
  assign u_wb.ex_dst = i_data_ExMemDst;
  assign u_wb.ex_res = i_data_ExMemRes;
  assign u_wb.mw_we  = i_con_MemWbRegWrite;
  assign u_wb.mw_dst = i_data_MemWbDst;
  assign u_wb.mw_res = i_data_MemWbRes;

  // Stores read rt even with an immediate B operand, so rt always counts for them.
  assign rt_hit   = (ex_q.wr_addr == i_data_RtAddr) && (!i_con_AluSrc || i_con_MemWrite);
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.wr_addr != '0) && i_con_IdValid &&
                    ((ex_q.wr_addr == i_data_RsAddr) || rt_hit);
  assign o_con_Stall = load_use || i_con_Hold;

  always_comb begin
    cap = '0;
    if (i_con_IdValid) begin
      cap.valid      = 1'b1;
      cap.alu_ctrl   = i_con_AluCtrl;
      cap.alu_src    = i_con_AluSrc;
      cap.reg_write  = i_con_RegWrite;
      cap.mem_read   = i_con_MemRead;
      cap.mem_write  = i_con_MemWrite;
      cap.mem_to_reg = i_con_MemToReg;
      cap.wr_addr    = i_con_RegDst ? i_data_RdAddr : i_data_RtAddr;
      cap.rs_addr    = i_data_RsAddr;
      cap.rt_addr    = i_data_RtAddr;
      cap.shamt      = i_data_shamt;
      cap.rs_val     = i_data_RsVal;
      cap.rt_val     = i_data_RtVal;
      cap.imm        = i_data_Imm;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (i_con_Flush)     ex_d = '0;
    else if (i_con_Hold) ex_d = ex_q;
    else if (load_use)   ex_d = '0;
    else                 ex_d = cap;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ex_q <= '0;
    else          ex_q <= ex_d;
  end

  fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs (
    .wb    (u_wb),
    .i_src (ex_q.rs_addr),
    .o_sel (sel_rs)
  );

  fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rt (
    .wb    (u_wb),
    .i_src (ex_q.rt_addr),
    .o_sel (sel_rt)
  );

  always_comb begin
    fwd_rs = ex_q.rs_val;
    fwd_rt = ex_q.rt_val;
    case (sel_rs)
      FWD_EXMEM: fwd_rs = u_wb.ex_res;
      FWD_MEMWB: fwd_rs = u_wb.mw_res;
      default:   fwd_rs = ex_q.rs_val;
    endcase
    case (sel_rt)
      FWD_EXMEM: fwd_rt = u_wb.ex_res;
      FWD_MEMWB: fwd_rt = u_wb.mw_res;
      default:   fwd_rt = ex_q.rt_val;
    endcase
  end

  assign o_data_A         = fwd_rs;
  assign o_data_B         = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign o_data_StoreData = fwd_rt;
  assign o_con_AluCtrl    = ex_q.alu_ctrl;
  assign o_data_shamt     = ex_q.shamt;
  assign o_data_WrAddr    = ex_q.wr_addr;
  assign o_con_RegWrite   = ex_q.reg_write;
  assign o_con_MemRead    = ex_q.mem_read;
  assign o_con_MemWrite   = ex_q.mem_write;
  assign o_con_MemToReg   = ex_q.mem_to_reg;
  assign o_con_ExValid    = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model; a FWD_EN=0 copy runs in parallel.
module tb_id_ex_stage;
  import arc_pkg::*;

  logic clk, rst_n;
  logic id_valid, alu_src, reg_dst, reg_wr, mem_rd, mem_wr, mem_to_reg, flush, hold;
  logic [31:0] rs_val, rt_val, imm;
  logic [4:0]  rs_a, rt_a, rd_a, shamt;
  logic [3:0]  alu;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  logic [31:0] a0, b0, st0, a1, b1, st1;
  logic [3:0]  alu0, alu1;
  logic [4:0]  sh0, sh1, wr0, wr1;
  logic rw0, mr0, mw0, m2r0, v0, stall0, rw1, mr1, mw1, m2r1, v1, stall1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the EX-stage contents
  logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
  logic [3:0]  m_alu;
  logic [4:0]  m_wr, m_rs, m_rt, m_sh;
  logic [31:0] m_rsv, m_rtv, m_imm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_con_IdValid(id_valid),
    .i_data_RsVal(rs_val), .i_data_RtVal(rt_val), .i_data_Imm(imm),
    .i_data_RsAddr(rs_a), .i_data_RtAddr(rt_a), .i_data_RdAddr(rd_a),
    .i_data_shamt(shamt), .i_con_AluCtrl(alu), .i_con_AluSrc(alu_src),
    .i_con_RegDst(reg_dst), .i_con_RegWrite(reg_wr), .i_con_MemRead(mem_rd),
    .i_con_MemWrite(mem_wr), .i_con_MemToReg(mem_to_reg), .i_con_Flush(flush),
    .i_con_Hold(hold), .i_con_ExMemRegWrite(bus.ex_we), .i_data_ExMemDst(bus.ex_dst),
    .i_data_ExMemRes(bus.ex_res), .i_con_MemWbRegWrite(bus.mw_we),
    .i_data_MemWbDst(bus.mw_dst), .i_data_MemWbRes(bus.mw_res),
    .o_data_A(a0), .o_data_B(b0), .o_con_AluCtrl(alu0), .o_data_shamt(sh0),
    .o_data_StoreData(st0), .o_data_WrAddr(wr0), .o_con_RegWrite(rw0),
    .o_con_MemRead(mr0), .o_con_MemWrite(mw0), .o_con_MemToReg(m2r0),
    .o_con_ExValid(v0), .o_con_Stall(stall0)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(0)) dut_nofwd (
    .i_clk(clk), .i_rst_n(rst_n), .i_con_IdValid(id_valid),
    .i_data_RsVal(rs_val), .i_data_RtVal(rt_val), .i_data_Imm(imm),
    .i_data_RsAddr(rs_a), .i_data_RtAddr(rt_a), .i_data_RdAddr(rd_a),
    .i_data_shamt(shamt), .i_con_AluCtrl(alu), .i_con_AluSrc(alu_src),
    .i_con_RegDst(reg_dst), .i_con_RegWrite(reg_wr), .i_con_MemRead(mem_rd),
    .i_con_MemWrite(mem_wr), .i_con_MemToReg(mem_to_reg), .i_con_Flush(flush),
    .i_con_Hold(hold), .i_con_ExMemRegWrite(bus.ex_we), .i_data_ExMemDst(bus.ex_dst),
    .i_data_ExMemRes(bus.ex_res), .i_con_MemWbRegWrite(bus.mw_we),
    .i_data_MemWbDst(bus.mw_dst), .i_data_MemWbRes(bus.mw_res),
    .o_data_A(a1), .o_data_B(b1), .o_con_AluCtrl(alu1), .o_data_shamt(sh1),
    .o_data_StoreData(st1), .o_data_WrAddr(wr1), .o_con_RegWrite(rw1),
    .o_con_MemRead(mr1), .o_con_MemWrite(mw1), .o_con_MemToReg(m2r1),
    .o_con_ExValid(v1), .o_con_Stall(stall1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_model(input int en, input logic [4:0] a, input logic [31:0] rf);
    if (en != 0 && a != 0 && bus.ex_we && bus.ex_dst == a) return bus.ex_res;
    if (en != 0 && a != 0 && bus.mw_we && bus.mw_dst == a) return bus.mw_res;
    return rf;
  endfunction

  function automatic logic model_lu();
    logic uses_rs, uses_rt;
    uses_rs = (m_wr == rs_a);
    uses_rt = (m_wr == rt_a) && (!alu_src || mem_wr);
    return m_valid && m_mr && m_wr != 0 && id_valid && (uses_rs || uses_rt);
  endfunction

  task automatic model_clear();
    {m_valid, m_src, m_rw, m_mr, m_mw, m_m2r} = '0;
    m_alu = '0; m_wr = '0; m_rs = '0; m_rt = '0; m_sh = '0;
    m_rsv = '0; m_rtv = '0; m_imm = '0;
  endtask

  task automatic compare_all();
    logic [31:0] ea, ert;
    logic        es;
    es  = model_lu() || hold;
    ea  = fwd_model(1, m_rs, m_rsv);
    ert = fwd_model(1, m_rt, m_rtv);
    check("stall", stall0, es);
    check("A", a0, ea);
    check("B", b0, m_src ? m_imm : ert);
    check("store", st0, ert);
    check("aluctrl", alu0, m_alu);
    check("shamt", sh0, m_sh);
    check("wraddr", wr0, m_wr);
    check("ctl", {v0, rw0, mr0, mw0, m2r0}, {m_valid, m_rw, m_mr, m_mw, m_m2r});
    ert = fwd_model(0, m_rt, m_rtv);
    check("nofwd_stall", stall1, es);
    check("nofwd_A", a1, fwd_model(0, m_rs, m_rsv));
    check("nofwd_B", b1, m_src ? m_imm : ert);
    check("nofwd_store", st1, ert);
    check("nofwd_ctl", {v1, wr1}, {m_valid, m_wr});
  endtask

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic tick();
    logic lu;
    lu = model_lu();
    @(posedge clk);
    #1;
    if (flush) model_clear();
    else if (hold) begin end
    else if (lu || !id_valid) model_clear();
    else begin
      m_valid = 1'b1; m_alu = alu; m_src = alu_src; m_rw = reg_wr; m_mr = mem_rd;
      m_mw = mem_wr; m_m2r = mem_to_reg; m_wr = reg_dst ? rd_a : rt_a;
      m_rs = rs_a; m_rt = rt_a; m_sh = shamt; m_rsv = rs_val; m_rtv = rt_val; m_imm = imm;
    end
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic rdst, input logic [3:0] op, input logic src,
                           input logic rw, input logic mr, input logic mw,
                           input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] im);
    id_valid = 1'b1; rs_a = rs; rt_a = rt; rd_a = rd; reg_dst = rdst; alu = op;
    alu_src = src; reg_wr = rw; mem_rd = mr; mem_wr = mw; mem_to_reg = mr;
    rs_val = rsv; rt_val = rtv; imm = im; shamt = 5'd0;
  endtask

  task automatic clear_wb();
    bus.ex_we = 1'b0; bus.ex_dst = '0; bus.ex_res = '0;
    bus.mw_we = 1'b0; bus.mw_dst = '0; bus.mw_res = '0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    clear_wb();
    model_clear();

    // Reset with active inputs: nothing may be captured
    set_instr(5'd1, 5'd2, 5'd3, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5, 32'h7, 32'h0);
    bus.ex_we = 1'b1; bus.ex_dst = 5'd1; bus.ex_res = 32'h77;
    repeat (2) @(posedge clk);
    #2;
    check("rst_A", a0, 32'h0);
    check("rst_B", b0, 32'h0);
    check("rst_ctl", {v0, rw0, mr0, mw0, m2r0, alu0, wr0}, '0);
    check("rst_stall", stall0, 1'b0);
    rst_n = 1'b1;
    clear_wb();

    // add $3,$1,$2
    set_instr(5'd1, 5'd2, 5'd3, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5, 32'h7, 32'h0);
    #1 compare_all(); tick();
    check("add_A", a0, 32'h5);
    check("add_B", b0, 32'h7);
    check("add_alu", alu0, 32'h2);
    check("add_wr", wr0, 32'h3);
    check("add_valid", v0, 1'b1);

    // Forwarding priority, with EX frozen
    set_instr(5'd4, 5'd2, 5'd1, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 32'h99, 32'h3, 32'h0);
    #1 tick();
    hold = 1'b1;
    bus.ex_we = 1'b1; bus.ex_dst = 5'd4; bus.ex_res = 32'h10;
    bus.mw_we = 1'b1; bus.mw_dst = 5'd4; bus.mw_res = 32'h20;
    #1 check("fwd_exmem", a0, 32'h10); check("nofwd_exmem", a1, 32'h99); compare_all();
    bus.ex_we = 1'b0;
    #1 check("fwd_memwb", a0, 32'h20); check("nofwd_memwb", a1, 32'h99); compare_all();
    bus.ex_we = 1'b1; bus.ex_dst = 5'd0; bus.mw_dst = 5'd0;
    #1 check("fwd_r0", a0, 32'h99); check("nofwd_r0", a1, 32'h99); compare_all();
    tick();
    hold = 1'b0; clear_wb();

    // Load-use: lw $5 in EX, add using $5 in ID
    set_instr(5'd1, 5'd5, 5'd0, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h4);
    #1 compare_all(); tick();
    set_instr(5'd5, 5'd2, 5'd6, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0);
    #1 check("lu_stall", stall0, 1'b1); compare_all(); tick();
    check("lu_bubble", {v0, rw0, mr0, mw0, alu0}, '0);
    check("lu_released", stall0, 1'b0);
    compare_all(); tick();
    check("lu_capture", {v0, wr0}, {1'b1, 5'd6});

    // Flush beats hold
    flush = 1'b1; hold = 1'b1;
    #1 compare_all(); tick();
    check("flush_bubble", v0, 1'b0);
    flush = 1'b0; hold = 1'b0;
    set_instr(5'd1, 5'd2, 5'd9, 1'b1, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h66, 32'h0);
    #1 compare_all(); tick();
    hold = 1'b1;
    set_instr(5'd7, 5'd8, 5'd10, 1'b1, ALU_XOR, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", stall0, 1'b1);
      check("hold_A", a0, 32'h55);
      check("hold_wr", wr0, 32'd9);
      compare_all(); tick();
    end
    hold = 1'b0;

    // Store: immediate B, rt forwarded from MEM/WB
    set_instr(5'd1, 5'd7, 5'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h11, 32'hFFFF_FFFC);
    #1 compare_all(); tick();
    bus.mw_we = 1'b1; bus.mw_dst = 5'd7; bus.mw_res = 32'hAB;
    #1 check("sw_B", b0, 32'hFFFF_FFFC); check("sw_store", st0, 32'hAB); compare_all();
    clear_wb();
    // Load-use on rt of a store
    set_instr(5'd1, 5'd5, 5'd0, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h8);
    #1 compare_all(); tick();
    set_instr(5'd2, 5'd5, 5'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4);
    #1 check("sw_lu_stall", stall0, 1'b1); compare_all();

    // Reset asserted while the load-use stall is pending
    rst_n = 1'b0; model_clear();
    #1 check("rst_mid_stall", stall0, 1'b0); check("rst_mid_valid", v0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 compare_all();

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      id_valid   = ($urandom_range(0, 7) != 0);
      rs_a       = 5'($urandom_range(0, 3));
      rt_a       = 5'($urandom_range(0, 3));
      rd_a       = 5'($urandom_range(0, 3));
      reg_dst    = 1'($urandom_range(0, 1));
      alu_src    = 1'($urandom_range(0, 1));
      alu        = 4'($urandom);
      shamt      = 5'($urandom);
      reg_wr     = 1'($urandom_range(0, 1));
      mem_rd     = ($urandom_range(0, 3) == 0);
      mem_wr     = ($urandom_range(0, 5) == 0);
      mem_to_reg = mem_rd;
      rs_val     = $urandom; rt_val = $urandom; imm = $urandom;
      flush      = ($urandom_range(0, 15) == 0);
      hold       = ($urandom_range(0, 7) == 0);
      bus.ex_we  = 1'($urandom_range(0, 1));
      bus.ex_dst = 5'($urandom_range(0, 3));
      bus.ex_res = $urandom;
      bus.mw_we  = 1'($urandom_range(0, 1));
      bus.mw_dst = 5'($urandom_range(0, 3));
      bus.mw_res = $urandom;
      #1 compare_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register plus EX-side operand forwarding for the ARC MIPS core. It captures decoded instructions and control from the decode stage every clock. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU operand, control and shamt inputs directly. It also detects load-use hazards and inserts bubbles, and supports flush (taken branch or jump) and hold (downstream stall).

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding active; 0 = operands always come from the registered register-file values (load-use stall still active)

Ports:
i_clk  in  1  clock; one clock domain
i_rst_n  in  1  reset, asynchronous, active-low
i_con_IdValid  in  1  decode stage holds a real instruction
i_data_RsVal  in  DATA_W  register-file rs value
i_data_RtVal  in  DATA_W  register-file rt value
i_data_Imm  in  DATA_W  extended immediate
i_data_RsAddr  in  REG_AW  rs index
i_data_RtAddr  in  REG_AW  rt index
i_data_RdAddr  in  REG_AW  rd index
i_data_shamt  in  5  shift amount
i_con_AluCtrl  in  4  ALU operation code
i_con_AluSrc  in  1  1 = B operand is Imm
i_con_RegDst  in  1  1 = destination is rd, else rt
i_con_RegWrite  in  1  instruction writes the register file
i_con_MemRead  in  1  load instruction
i_con_MemWrite  in  1  store instruction
i_con_MemToReg  in  1  writeback selects memory data
i_con_Flush  in  1  squash the instruction entering EX
i_con_Hold  in  1  downstream stall; freeze the stage
i_con_ExMemRegWrite  in  1  EX/MEM stage writes a register
i_data_ExMemDst  in  REG_AW  EX/MEM destination register
i_data_ExMemRes  in  DATA_W  EX/MEM ALU result
i_con_MemWbRegWrite  in  1  MEM/WB stage writes a register
i_data_MemWbDst  in  REG_AW  MEM/WB destination register
i_data_MemWbRes  in  DATA_W  MEM/WB writeback value
o_data_A  out  DATA_W  ALU operand A
o_data_B  out  DATA_W  ALU operand B
o_con_AluCtrl  out  4  to ALU
o_data_shamt  out  5  to ALU
o_data_StoreData  out  DATA_W  forwarded rt value for stores
o_data_WrAddr  out  REG_AW  resolved destination register
o_con_RegWrite, o_con_MemRead, o_con_MemWrite, o_con_MemToReg  out  1 each  registered control
o_con_ExValid  out  1  EX holds a real instruction
o_con_Stall  out  1  upstream (PC and IF/ID) must hold

Behaviour:
- Reset (async on i_rst_n low): all registered fields clear to 0.
  - Resulting outputs: o_data_A=0, o_data_B=0, all control outputs 0, o_data_WrAddr=0.
  - o_con_Stall = i_con_Hold.
- Load-use detection (combinational):
  - load_use = ExValid & MemRead & WrAddr!=0 & i_con_IdValid & (WrAddr==RsAddr | (WrAddr==RtAddr & !i_con_AluSrc)).
  - Stores use rt when AluSrc=1, so for i_con_MemWrite the rt term is used regardless of AluSrc.
  - o_con_Stall = load_use | i_con_Hold.
- Register update priority at each rising clock edge:
  1. reset
  2. i_con_Flush: load a bubble
  3. i_con_Hold: keep contents
  4. load_use: load a bubble
  5. otherwise capture ID inputs
- Flush and Hold asserted together: flush wins.
- Bubble: all fields 0 (ExValid=0, RegWrite=MemRead=MemWrite=0, AluCtrl=0).
- WrAddr = RegDst ? RdAddr : RtAddr, resolved at capture.
- Capture with i_con_IdValid=0 stores a bubble.
- Forwarding, per operand (rs, rt), combinational on registered addresses:
  - Source is EX/MEM if ExMemRegWrite & ExMemDst!=0 & ExMemDst==addr.
  - Otherwise MEM/WB under the same conditions.
  - Otherwise the registered register-file value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand outputs:
  - o_data_A = fwd(rs).
  - o_data_B = AluSrc ? Imm : fwd(rt).
  - o_data_StoreData = fwd(rt).
- Latency: one cycle from ID to EX outputs. Forwarded operands have zero latency relative to the EX/MEM and MEM/WB inputs.
- Reset deasserted mid-stall: the stage restarts empty and there is no pending stall.

Decomposition:
- Package arc_pkg:
  - ALU control constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SRL=4, ALU_SEQ=5, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_XOR=13.
  - Enum fwd_sel_e {FWD_RF, FWD_EXMEM, FWD_MEMWB}.
  - Packed struct id_ex_t holding all registered fields.
- Sub-module fwd_unit: combinational, takes one source address plus both writeback ports and returns fwd_sel_e. Instantiated twice, once for rs and once for rt.

Test Plan:
1. Reset:
   - Hold i_rst_n=0, drive inputs active -> all outputs 0 and o_con_Stall=0.
   - Release reset, capture add $3,$1,$2 (RsVal=5, RtVal=7) -> next cycle A=5, B=7, AluCtrl=2, WrAddr=3, ExValid=1.
2. Forwarding priority:
   - EX add $1 (RsAddr=4) with ExMemDst=4 / Res=0x10 and MemWbDst=4 / Res=0x20, both RegWrite=1 -> A=0x10.
   - Drop ExMemRegWrite -> A=0x20.
   - Set dst=0 -> A=RsVal.
3. Load-use:
   - EX holds lw $5 (MemRead=1, WrAddr=5), ID has add using rs=5 -> o_con_Stall=1; next cycle ExValid=0 with controls 0; ID instruction then captures when it is re-presented.
4. Flush vs hold:
   - i_con_Flush=1 with i_con_Hold=1 -> bubble loaded.
   - i_con_Hold alone for 3 cycles -> outputs unchanged and o_con_Stall=1 throughout.
5. Immediate / store:
   - sw with AluSrc=1, Imm=0xFFFFFFFC, rt forwarded from MEM/WB value 0xAB -> B=0xFFFFFFFC, StoreData=0xAB.
   - Load-use on rt for the store also stalls.
6. FWD_EN=0 build:
   - Scenario 2 stimulus -> A=RsVal for every case.
